// File: rtl/core_mem_bus_pkg.sv
// Shared types and constants for the core memory/I-O subsystem.
package core_mem_bus_pkg;

  // Subsystem mode: LOAD fills the RAM from the host, RUN serves the core.
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // What a core address selects.
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_LED  = 2'd2,
    TGT_CNT  = 2'd3
  } target_e;

  localparam logic [7:0] MMIO_PAGE = 8'hFF;
  localparam logic [7:0] LED_OFF   = 8'h00;
  localparam logic [7:0] CNT_OFF   = 8'h01;

  // Page 0x00 is RAM; the MMIO page holds the LED register and the counter.
  function automatic target_e decode_addr(input logic [15:0] addr,
                                          input logic [7:0]  mmio_page);
    target_e tgt;
    tgt = TGT_NONE;
    if (addr[15:8] == 8'h00)
      tgt = TGT_RAM;
    else if (addr[15:8] == mmio_page && addr[7:0] == LED_OFF)
      tgt = TGT_LED;
    else if (addr[15:8] == mmio_page && addr[7:0] == CNT_OFF)
      tgt = TGT_CNT;
    return tgt;
  endfunction

endpackage

// File: rtl/core_mem_ram.sv
// Single-port unified instruction/data RAM with a read-first registered output.
module core_mem_ram
  import core_mem_bus_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write and read on the same edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/core_mem_bus.sv
// Memory and I/O subsystem for the 16-bit core: unified RAM, LED register,
// cycle counter and a host program-loader port that holds the core.
module core_mem_bus
  import core_mem_bus_pkg::*;
#(
  parameter int         AW        = 8,
  parameter int         DW        = 16,
  parameter logic [7:0] MMIO_PAGE = core_mem_bus_pkg::MMIO_PAGE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   Address,
  input  logic [DW-1:0] WriteData,
  input  logic          WriteEnable,
  output logic [DW-1:0] ReadData,
  output logic          core_hold,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          ld_start,
  output logic [DW-1:0] led
);

  state_e        state;
  logic          run;
  logic          ld_fire;
  target_e       tgt;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [15:0]   cnt;
  logic [DW-1:0] mmio_val;
  logic [DW-1:0] mmio_rdata_p1;
  logic          sel_ram_p1;

  assign run       = (state == RUN);
  assign ld_ready  = ~run;
  assign core_hold = ~run;
  assign ld_fire   = ld_valid & ld_ready;
  assign tgt       = decode_addr(Address, MMIO_PAGE);

  // The single RAM port belongs to the loader in LOAD and to the core in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ld_addr;
    ram_wdata = ld_data;
    if (run) begin
      ram_we    = WriteEnable & (tgt == TGT_RAM);
      ram_addr  = Address[AW-1:0];
      ram_wdata = WriteData;
    end else begin
      ram_we    = ld_fire;
    end
  end

  core_mem_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Mode FSM: last loaded word starts the core, ld_start hands back to the loader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      case (state)
        LOAD:    if (ld_fire && ld_last) state <= RUN;
        RUN:     if (ld_start)           state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  // LED register, written by the core only while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      led <= '0;
    else if (run && WriteEnable && tgt == TGT_LED)
      led <= WriteData;
  end

  // Cycle counter: parked at zero outside RUN so it restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!run)
      cnt <= '0;
    else
      cnt <= cnt + 16'd1;
  end

  // MMIO read value taken before this edge's updates (read-first).
  always_comb begin
    mmio_val = '0;
    case (tgt)
      TGT_LED: mmio_val = led;
      TGT_CNT: mmio_val = DW'(cnt);
      default: mmio_val = '0;
    endcase
  end

  // ---- stage p1: MMIO read registered to line up with the RAM output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ram_p1    <= 1'b0;
      mmio_rdata_p1 <= '0;
    end else begin
      sel_ram_p1    <= run && (tgt == TGT_RAM);
      mmio_rdata_p1 <= run ? mmio_val : '0;
    end
  end

  assign ReadData = sel_ram_p1 ? ram_rdata : mmio_rdata_p1;

endmodule

// File: tb/tb_core_mem_bus.sv
// Directed bench for core_mem_bus: load, RAM/MMIO access, counter, reset, reload.
module tb_core_mem_bus;

  logic        clk;
  logic        rst;
  logic [15:0] Address;
  logic [15:0] WriteData;
  logic        WriteEnable;
  logic [15:0] ReadData;
  logic        core_hold;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_start;
  logic [15:0] led;

  int errors;
  int checks;
  int edges;
  int base;

  core_mem_bus #(
    .AW        (8),
    .DW        (16),
    .MMIO_PAGE (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Address     (Address),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .ReadData    (ReadData),
    .core_hold   (core_hold),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_start    (ld_start),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic core_rd(input logic [15:0] a);
    Address     = a;
    WriteEnable = 1'b0;
    step();
  endtask

  task automatic core_wr(input logic [15:0] a, input logic [15:0] d);
    Address     = a;
    WriteData   = d;
    WriteEnable = 1'b1;
    step();
    WriteEnable = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; edges = 0; base = 0;
    rst = 1'b1;
    Address = '0; WriteData = '0; WriteEnable = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; ld_start = 1'b0;
    step();
    step();
    chk("rst_readdata", ReadData, 16'h0000);
    chk("rst_led", led, 16'h0000);
    chk("rst_hold", {15'd0, core_hold}, 16'd1);
    chk("rst_ready", {15'd0, ld_ready}, 16'd1);
    rst = 1'b0;

    // Initial image; ld_last on the third word.
    load_word(8'h00, 16'h1111, 1'b0);
    load_word(8'h01, 16'h2222, 1'b0);
    chk("load_hold_mid", {15'd0, core_hold}, 16'd1);
    load_word(8'h02, 16'h3333, 1'b1);
    base = edges;
    chk("run_hold", {15'd0, core_hold}, 16'd0);
    chk("run_ready", {15'd0, ld_ready}, 16'd0);

    // RUN edges 1..10; loader traffic during RUN must be ignored.
    core_rd(16'h0001);
    chk("rd_addr1", ReadData, 16'h2222);
    core_rd(16'h0000);
    chk("rd_addr0", ReadData, 16'h1111);
    core_rd(16'hFF01);
    chk("cnt_edge3", ReadData, 16'd2);
    ld_valid = 1'b1; ld_addr = 8'h01; ld_data = 16'hDEAD;
    core_rd(16'h0002);
    chk("rd_addr2_last", ReadData, 16'h3333);
    while ((edges - base) < 9) core_rd(16'h0002);
    ld_valid = 1'b0;
    core_rd(16'hFF01);
    chk("cnt_edge10", ReadData, 16'd9);

    // RAM write, readback, and read-first on a same-edge read/write.
    core_wr(16'h0005, 16'hBEEF);
    core_rd(16'h0005);
    chk("ram_wr_rd", ReadData, 16'hBEEF);
    core_wr(16'h0005, 16'h1234);
    chk("ram_read_first", ReadData, 16'hBEEF);
    core_rd(16'h0005);
    chk("ram_new_value", ReadData, 16'h1234);
    core_rd(16'h0001);
    chk("ld_ignored_run", ReadData, 16'h2222);

    // LED register and unmapped addresses.
    core_wr(16'hFF00, 16'h00A5);
    chk("led_port", led, 16'h00A5);
    core_rd(16'hFF00);
    chk("led_readback", ReadData, 16'h00A5);
    core_rd(16'h8000);
    chk("unmapped_rd", ReadData, 16'h0000);
    core_wr(16'h8000, 16'hFFFF);
    chk("unmapped_wr_rd", ReadData, 16'h0000);
    core_rd(16'h0000);
    chk("unmapped_no_ram", ReadData, 16'h1111);
    chk("unmapped_no_led", led, 16'h00A5);

    // ld_start with a simultaneous core write: write lands, block returns to LOAD.
    Address = 16'h0010; WriteData = 16'h7777; WriteEnable = 1'b1; ld_start = 1'b1;
    step();
    WriteEnable = 1'b0; ld_start = 1'b0;
    chk("reload_hold", {15'd0, core_hold}, 16'd1);
    chk("reload_ready", {15'd0, ld_ready}, 16'd1);

    // Core writes are ignored in LOAD and ReadData stays 0.
    core_wr(16'h0005, 16'hAAAA);
    chk("load_readdata_zero", ReadData, 16'h0000);

    // Two loader words, then an asynchronous reset mid-load.
    load_word(8'h20, 16'h4444, 1'b0);
    load_word(8'h21, 16'h5555, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", led, 16'h0000);
    chk("async_rst_hold", {15'd0, core_hold}, 16'd1);
    step();
    rst = 1'b0;

    // ld_last without ld_valid does nothing.
    ld_last = 1'b1;
    step();
    ld_last = 1'b0;
    chk("last_no_valid", {15'd0, core_hold}, 16'd1);

    load_word(8'h22, 16'h6666, 1'b1);
    base = edges;
    chk("reload_run", {15'd0, core_hold}, 16'd0);
    core_rd(16'h0020);
    chk("kept_w20", ReadData, 16'h4444);
    core_rd(16'h0021);
    chk("kept_w21", ReadData, 16'h5555);
    core_rd(16'h0010);
    chk("ld_start_write", ReadData, 16'h7777);
    core_rd(16'h0005);
    chk("load_core_wr_ignored", ReadData, 16'h1234);
    core_rd(16'hFF00);
    chk("led_after_rst", ReadData, 16'h0000);
    core_rd(16'hFF01);
    chk("cnt_restart", ReadData, 16'd5);
    core_rd(16'h0022);
    chk("new_word", ReadData, 16'h6666);

    // Run the counter up to its wrap point.
    Address = 16'hFF01;
    while ((edges - base) < 65535) step();
    step();
    chk("cnt_ffff", ReadData, 16'hFFFF);
    step();
    chk("cnt_wrap", ReadData, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_mem_bus.md
# core_mem_bus

Memory and I/O subsystem sitting directly downstream of the 16-bit core: it answers the core's Address/WriteData/WriteEnable bus with a registered ReadData, one cycle after the address. It contains the 256-word unified instruction/data RAM, a memory-mapped LED register and a cycle counter. It also provides a host program-loader port that fills the RAM while the core is held.

## Interface
Parameters:
- AW, 8: RAM word-address width (depth 2^AW).
- DW, 16: data width.
- MMIO_PAGE, 8'hFF: upper address byte selecting the I/O page.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- Address  in  16  core word address.
- WriteData  in  16  core write data.
- WriteEnable  in  1  core write strobe; connects to bit 0 of the core's output.
- ReadData  out  16  registered read data to the core.
- core_hold  out  1  high while loading; holds the core.
- ld_valid  in  1  host word valid.
- ld_ready  out  1  loader accepting.
- ld_addr  in  AW  RAM word address for the host word.
- ld_data  in  16  host word.
- ld_last  in  1  marks the final word of the image.
- ld_start  in  1  RUN-state request to reload.
- led  out  16  LED register.

## Operation
- States: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - ld_ready=1 and core_hold=1.
  - A word is accepted on any edge where ld_valid&ld_ready: ram[ld_addr]<=ld_data.
  - An accepted word with ld_last=1 moves the block to RUN on the same edge.
  - Core accesses are ignored.
  - ReadData is driven 0.
- RUN:
  - ld_ready=0 and core_hold=0.
  - ld_valid is ignored.
  - ld_start=1 returns the block to LOAD on the next edge. A core write in that same cycle still completes.
- Address decode in RUN:
  - Address[15:8]==0: RAM word Address[AW-1:0], read/write.
  - MMIO_PAGE:00: led register, read/write.
  - MMIO_PAGE:01: cycle counter, read-only; writes are ignored.
  - Any other address: reads return 0; writes are ignored.
- Writes: the target is updated on the edge where WriteEnable=1.
- Reads: ReadData<=value(Address) on every RUN edge.
  - A read and a write to the same location on the same edge return the old value (read-first).
- Cycle counter:
  - 16 bits; cleared on entry to RUN.
  - Increments every RUN edge and wraps 0xFFFF->0x0000.
  - A read returns the pre-increment value.
- RAM contents are not affected by reset; contents survive a reload except for the words rewritten.

## Timing
- Reset values: state=LOAD, ReadData=0, led=0, counter=0, core_hold=1, ld_ready=1.
- Reset asserted mid-load aborts the load immediately; words already written remain in RAM.
- Read latency is one cycle: Address presented in cycle n gives ReadData valid in cycle n+1.
  - This matches the core's Fetch->Receive and Receive->Load sequence.
- Write latency is zero: the location is updated at the end of the cycle in which WriteEnable is high.
- Loader throughput is one word per cycle.
- core_hold falls in the first cycle after the ld_last handshake edge.
- The first RUN-cycle read therefore returns ram[Address] as of that edge, including the last loaded word.
- ld_start asserted in LOAD has no effect.
- ld_last without ld_valid has no effect.

## Structure
- Shared package: state enum {LOAD, RUN}, MMIO_PAGE, and offsets LED_OFF=8'h00, CNT_OFF=8'h01.
- One sub-module: core_mem_ram, a single-port RAM with a read-first registered output.
  - The top level muxes the write port between the loader and the core by state.
  - It registers the MMIO read path so that RAM and MMIO reads have equal latency.

## Test plan
- Load 0x1111@0, 0x2222@1, 0x3333@2 with ld_last on the third word -> core_hold falls in the next cycle; reading Address 1 returns 0x2222 one cycle later.
- RUN: write 0xBEEF to 0x0005, then read 0x0005 -> 0xBEEF. Write and read 0x0005 on the same edge with new data 0x1234 -> ReadData=0xBEEF, the next read returns 0x1234.
- Write 0x00A5 to 0xFF00 -> led=0x00A5 after the edge; reading 0xFF00 returns 0x00A5. Reading 0x8000 returns 0, and writing 0x8000 has no effect.
- Read 0xFF01 on the 3rd and 10th RUN edges -> 2 and 9. Force the counter to 0xFFFF -> it reads 0x0000 on the following edge's read.
- Assert rst after two loader words, then reload one word with ld_last -> the two earlier words are still in RAM, led=0, counter restarted at 0.
- In RUN, assert ld_start together with a core write of 0x7777 to 0x0010 -> state=LOAD next cycle, ld_ready=1, and ram[0x10]=0x7777 after reload.
